// File: rtl/matrix_bram_pkg.sv
// Shared types and constants for the matrix stream BRAM block.
package matrix_bram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } state_t;

   localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/matrix_stream_bram_if.sv
// Avalon-MM slave bus plus the outgoing word stream of matrix_stream_bram.
interface matrix_stream_bram_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 6
);

   logic [ADDR_WIDTH-1:0]   address;
   logic                    chipselect;
   logic                    write;
   logic                    read;
   logic [DATA_WIDTH/8-1:0] byteenable;
   logic [DATA_WIDTH-1:0]   writedata;
   logic [DATA_WIDTH-1:0]   readdata;
   logic                    readdatavalid;
   logic [DATA_WIDTH-1:0]   stream_data;
   logic                    stream_valid;
   logic                    stream_ready;

   modport slave (
      input  address, chipselect, write, read, byteenable, writedata, stream_ready,
      output readdata, readdatavalid, stream_data, stream_valid
   );

   modport master (
      output address, chipselect, write, read, byteenable, writedata, stream_ready,
      input  readdata, readdatavalid, stream_data, stream_valid
   );

endinterface

// File: rtl/matrix_bram_core.sv
// Dual-port inferred RAM: byte-enabled read/write port A, read-only port B,
// both with one-cycle registered reads (read-before-write on port A).
module matrix_bram_core #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
   parameter string       INIT_FILE  = ""
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    a_en,
   input  logic                    a_we,
   input  logic [DATA_WIDTH/8-1:0] a_be,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH-1:0]   a_wdata,
   output logic [DATA_WIDTH-1:0]   a_rdata,
   input  logic                    b_en,
   input  logic [ADDR_WIDTH-1:0]   b_addr,
   output logic [DATA_WIDTH-1:0]   b_rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (a_we) begin
         for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
            if (a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) a_rdata <= '0;
      else if (a_en) a_rdata <= mem[a_addr];
   end

   always_ff @(posedge clk) begin
      if (b_en) b_rdata <= mem[b_addr];
   end

endmodule

// File: rtl/matrix_stream_bram.sv
// Avalon-MM slave BRAM that also streams bursts of words to a systolic array
// through a 2-entry skid buffer on its second read port.
module matrix_stream_bram
   import matrix_bram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
   parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1,
   parameter string       INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  reset,
   matrix_stream_bram_if.slave   bus,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic [LEN_WIDTH-1:0]  to_issue, to_xfer;
   logic                  inflight;
   logic [1:0]            count, occ;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] fifo [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] a_rdata, b_rdata;
   logic                  rdv_q;
   logic                  pop, pop_fifo, push, issue, load, done_d, busy_d;

   matrix_bram_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .a_en    (bus.chipselect && bus.read && !bus.write),
      .a_we    (bus.chipselect && bus.write),
      .a_be    (bus.byteenable),
      .a_addr  (bus.address),
      .a_wdata (bus.writedata),
      .a_rdata (a_rdata),
      .b_en    (issue),
      .b_addr  (fetch_addr),
      .b_rdata (b_rdata)
   );

   assign bus.readdata      = a_rdata;
   assign bus.readdatavalid = rdv_q;

   // A word arriving into an empty buffer is presented straight from the RAM
   // register, which is what gives the two-cycle start-to-valid latency.
   assign bus.stream_valid = inflight || (count != '0);
   assign bus.stream_data  = (count != '0) ? fifo[rd_ptr] : (inflight ? b_rdata : '0);

   assign pop      = bus.stream_valid && bus.stream_ready;
   assign pop_fifo = pop && (count != '0);
   assign push     = inflight && !((count == '0) && bus.stream_ready);
   assign occ      = 2'(inflight) + count;
   // The slot freed by this cycle's transfer is credited so a ready sink sees one word per cycle.
   assign issue    = (state == STREAM) && ((occ - 2'(pop)) < 2'(BUF_DEPTH));

   always_comb begin
      state_d = state;
      load    = 1'b0;
      done_d  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = STREAM;
                  load    = 1'b1;
               end
            end
         end
         STREAM: begin
            if (issue && (to_issue == LEN_WIDTH'(1))) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && (to_xfer == LEN_WIDTH'(1))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) || ((state == DRAIN) && done_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         done       <= 1'b0;
         busy       <= 1'b0;
         rdv_q      <= 1'b0;
         inflight   <= 1'b0;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fetch_addr <= '0;
         to_issue   <= '0;
         to_xfer    <= '0;
      end else begin
         state    <= state_d;
         done     <= done_d;
         busy     <= busy_d;
         rdv_q    <= bus.chipselect && bus.read && !bus.write;
         inflight <= issue;
         if (load) begin
            fetch_addr <= base_addr;
            to_issue   <= length;
            to_xfer    <= length;
         end else begin
            if (issue) begin
               fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
               to_issue   <= to_issue - LEN_WIDTH'(1);
            end
            if (pop) to_xfer <= to_xfer - LEN_WIDTH'(1);
         end
         if (push) begin
            fifo[wr_ptr] <= b_rdata;
            wr_ptr       <= wr_ptr + PTR_W'(1);
         end
         if (pop_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + 2'(push) - 2'(pop_fifo);
      end
   end

endmodule

// File: tb/tb_matrix_stream_bram.sv
// Scoreboard bench for matrix_stream_bram: slave access, bursts, backpressure, reset abort.
module tb_matrix_stream_bram;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [5:0] base_addr;
   logic [6:0] length;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   matrix_stream_bram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

   matrix_stream_bram #(.DATA_WIDTH(32), .DEPTH(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc_cnt = 0;
   int unsigned start_cyc = 0;
   int unsigned first_lat = 999;
   bit          first_pending = 1'b0;
   int unsigned xfer_cnt = 0;
   int unsigned done_cnt = 0;
   int unsigned valid_seen = 0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic [31:0] model [64];
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 32'(bus.stream_valid), 32'd1);
            check("hold_data", bus.stream_data, prev_data);
         end
         if (bus.stream_valid) valid_seen++;
         if (first_pending && bus.stream_valid) begin
            first_lat     = cyc_cnt - start_cyc;
            first_pending = 1'b0;
         end
         if (bus.stream_valid && bus.stream_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) check("sb_extra", 32'(exp_q.size()), 32'd1);
            else check("stream", bus.stream_data, exp_q.pop_front());
         end
         if (done) done_cnt++;
         prev_stall = bus.stream_valid && !bus.stream_ready;
         prev_data  = bus.stream_data;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic slave_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.address    = a;
      bus.writedata  = d;
      bus.byteenable = be;
      for (int unsigned i = 0; i < 4; i++) if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
      cyc();
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
   endtask

   task automatic slave_read(input logic [5:0] a, input string tag);
      logic [31:0] exp;
      exp = model[a];
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.address    = a;
      check("rdv_pre", 32'(bus.readdatavalid), 32'd0);
      cyc();
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      check("rdv", 32'(bus.readdatavalid), 32'd1);
      check(tag, bus.readdata, exp);
      cyc();
      check("rdv_post", 32'(bus.readdatavalid), 32'd0);
   endtask

   task automatic drive_start(input logic [5:0] b, input logic [6:0] len, input logic rdy);
      start            = 1'b1;
      base_addr        = b;
      length           = len;
      bus.stream_ready = rdy;
      start_cyc        = cyc_cnt;
      first_pending    = (len != 0);
      first_lat        = 999;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned duty, input bit stray, output int unsigned lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      for (int unsigned t = 0; t < 4000 && !seen; t++) begin
         if (stray) begin
            start     = (t == 2);
            base_addr = 6'd0;
            length    = 7'd3;
         end
         bus.stream_ready = (duty >= 100) || ($urandom_range(99) < duty);
         if (done) begin
            seen = 1'b1;
            lat  = cyc_cnt - start_cyc;
         end else begin
            cyc();
         end
      end
      start = 1'b0;
      check("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic run_burst(input logic [5:0] b, input logic [6:0] len, input int unsigned duty,
                            input bit stray, input string tag);
      int unsigned x0, lat;
      x0 = xfer_cnt;
      for (int unsigned i = 0; i < len; i++) exp_q.push_back(model[(int'(b) + i) % 64]);
      drive_start(b, len, (duty >= 100) || ($urandom_range(99) < duty));
      check({tag, "_busy"}, 32'(busy), 32'(len != 0));
      wait_done(duty, stray, lat);
      check({tag, "_busy_done"}, 32'(busy), 32'(len != 0));
      if (duty >= 100) check({tag, "_done_lat"}, lat, (len == 0) ? 32'd1 : 32'(len) + 32'd2);
      if (len != 0) check({tag, "_first_lat"}, first_lat, 32'd2);
      bus.stream_ready = 1'b0;
      cyc();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_xfers"}, xfer_cnt - x0, 32'(len));
      check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int unsigned x0, d0, v0, lat;
      reset            = 1'b1;
      start            = 1'b0;
      base_addr        = '0;
      length           = '0;
      bus.chipselect   = 1'b0;
      bus.write        = 1'b0;
      bus.read         = 1'b0;
      bus.address      = '0;
      bus.byteenable   = '0;
      bus.writedata    = '0;
      bus.stream_ready = 1'b0;
      repeat (3) cyc();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_svalid", 32'(bus.stream_valid), 32'd0);
      check("rst_sdata", bus.stream_data, 32'd0);
      check("rst_rdv", 32'(bus.readdatavalid), 32'd0);
      check("rst_rdata", bus.readdata, 32'd0);
      reset = 1'b0;
      cyc();

      for (int unsigned i = 0; i < 64; i++) slave_write(6'(i), i, 4'hF);

      slave_write(6'd5, 32'hDEADBEEF, 4'b0011);
      check("be_model", model[5], 32'h0000BEEF);
      slave_read(6'd5, "be_read");
      slave_write(6'd5, 32'd5, 4'hF);
      slave_read(6'd40, "read40");

      run_burst(6'd10, 7'd8, 100, 1'b0, "b10");
      run_burst(6'd62, 7'd4, 100, 1'b0, "wrap");
      run_burst(6'd0, 7'd64, 30, 1'b0, "rand");

      v0 = valid_seen;
      d0 = done_cnt;
      run_burst(6'd7, 7'd0, 100, 1'b0, "len0");
      check("len0_no_valid", valid_seen - v0, 32'd0);
      check("len0_done_cnt", done_cnt - d0, 32'd1);

      x0 = xfer_cnt;
      d0 = done_cnt;
      run_burst(6'd10, 7'd8, 100, 1'b1, "stray");
      repeat (6) cyc();
      check("stray_xfers", xfer_cnt - x0, 32'd8);
      check("stray_dones", done_cnt - d0, 32'd1);

      // Live write into an unfetched word versus an already-fetched one.
      for (int unsigned i = 0; i < 8; i++) exp_q.push_back((i == 5) ? 32'hCAFE0025 : model[20 + i]);
      x0 = xfer_cnt;
      drive_start(6'd20, 7'd8, 1'b0);
      repeat (6) cyc();
      slave_write(6'd25, 32'hCAFE0025, 4'hF);
      slave_write(6'd20, 32'h00000BAD, 4'hF);
      wait_done(100, 1'b0, lat);
      bus.stream_ready = 1'b0;
      cyc();
      check("live_xfers", xfer_cnt - x0, 32'd8);
      check("live_sb_left", 32'(exp_q.size()), 32'd0);

      slave_read(6'd3, "pre_rst_read");
      for (int unsigned i = 0; i < 8; i++) exp_q.push_back(model[i]);
      x0 = xfer_cnt;
      d0 = done_cnt;
      drive_start(6'd0, 7'd8, 1'b1);
      while (cyc_cnt < start_cyc + 4) cyc();
      reset = 1'b1;
      cyc();
      check("abort_xfers", xfer_cnt - x0, 32'd2);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_svalid", 32'(bus.stream_valid), 32'd0);
      check("abort_sdata", bus.stream_data, 32'd0);
      check("abort_rdv", 32'(bus.readdatavalid), 32'd0);
      check("abort_rdata", bus.readdata, 32'd0);
      reset = 1'b0;
      exp_q.delete();
      first_pending = 1'b0;
      repeat (12) cyc();
      check("abort_no_done", done_cnt - d0, 32'd0);
      check("abort_no_valid", 32'(bus.stream_valid), 32'd0);
      slave_read(6'd3, "mem_kept3");
      slave_read(6'd25, "mem_kept25");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
